// File: rtl/fsm_output_ram_reader.sv
// ---------------------------------------------------------------------------
// fsm_output_ram_reader
//
// Purpose:
//    Read-side partner of the input FSM that fills the shared message RAM.
//    The writer's address counter is taken as the fill level. This block keeps
//    its own read pointer and pulls words back out in write order, one word
//    per start request. Each word is fetched from a synchronous RAM, held in
//    a capture register and offered on a valid/ready handshake. A one-cycle
//    finished pulse follows every accepted word.
//
// Parameters:
//    ADDR_WIDTH   RAM address width; also the read pointer and count width
//    DATA_WIDTH   RAM word width
//    RAM_LATENCY  cycles from the read-enable cycle to valid ram_data (1..4)
//
// Ports:
//    clk                   in   system clock, rising edge active
//    reset_n               in   asynchronous active-low reset
//    start                 in   request one word (looked at in IDLE only)
//    rewind                in   clear the read pointer (IDLE only, beats start)
//    write_count           in   number of words stored by the writer
//    ram_data              in   RAM read data
//    tx_ready              in   transmitter takes the offered word this cycle
//    address               out  RAM read address (zero outside READ)
//    read_enable           out  RAM read strobe (READ only)
//    data_to_transmission  out  captured word, always shows the register
//    data_valid            out  captured word is being offered
//    finished              out  one-cycle pulse after each accepted word
//    empty                 out  no unread words
//    words_available       out  number of unread words, modulo 2^ADDR_WIDTH
// ---------------------------------------------------------------------------
module fsm_output_ram_reader #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  rewind,
   input  logic [ADDR_WIDTH-1:0] write_count,
   input  logic [DATA_WIDTH-1:0] ram_data,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  read_enable,
   output logic [DATA_WIDTH-1:0] data_to_transmission,
   output logic                  data_valid,
   output logic                  finished,
   output logic                  empty,
   output logic [ADDR_WIDTH-1:0] words_available
);

   // Three bits comfortably hold the largest reload value (RAM_LATENCY-1 = 3).
   localparam int WAIT_WIDTH = 3;
   localparam logic [WAIT_WIDTH-1:0] WAIT_RELOAD = WAIT_WIDTH'(RAM_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      WAIT    = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                  state_q,    state_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [WAIT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DATA_WIDTH-1:0]   data_reg_q, data_reg_d;

   // Fill level is a plain modulo difference between the writer's counter and
   // our pointer, so it stays right when either side wraps past the top of
   // the address space. It follows rd_ptr directly, which is why the count
   // already drops in the DONE cycle right after the handshake edge.
   always_comb begin
      words_available = write_count - rd_ptr_q;
      empty           = (words_available == '0);
   end

   // The captured word is shown in every state, not just PRESENT, so the
   // transmit side never sees anything but the last word read (or zero).
   always_comb begin
      data_to_transmission = data_reg_q;
   end

   // All architectural state lives here. Reset is asynchronous so a reset in
   // the middle of a transfer drops the word at once; the pointer is cleared
   // along with it, so nothing half-read is ever counted as consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wait_cnt_q <= '0;
         data_reg_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         data_reg_q <= data_reg_d;
      end
   end

   // Next-state and output decode. Every register holds and every strobe is
   // low by default, so each state only spells out what it changes.
   //
   // IDLE   : rewind wins over start; a start while empty is simply dropped.
   // READ   : one-cycle strobe of the current pointer onto the RAM port.
   // WAIT   : counts down RAM_LATENCY cycles; the count reaches zero on the
   //          cycle the RAM output becomes valid, which is when we capture.
   // PRESENT: offer the word until tx_ready; the pointer advances only on the
   //          accepting edge, so a stalled word is never skipped.
   // DONE   : single-cycle completion pulse, then back to IDLE.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      data_reg_d  = data_reg_q;
      address     = '0;
      read_enable = 1'b0;
      data_valid  = 1'b0;
      finished    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rewind) begin
               rd_ptr_d = '0;
            end else if (start && !empty) begin
               state_d = READ;
            end
         end

         READ: begin
            read_enable = 1'b1;
            address     = rd_ptr_q;
            wait_cnt_d  = WAIT_RELOAD;
            state_d     = WAIT;
         end

         WAIT: begin
            if (wait_cnt_q == '0) begin
               data_reg_d = ram_data;
               state_d    = PRESENT;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_WIDTH'(1);
            end
         end

         PRESENT: begin
            data_valid = 1'b1;
            if (tx_ready) begin
               rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
               state_d  = DONE;
            end
         end

         DONE: begin
            finished = 1'b1;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fsm_output_ram_reader.sv
// ---------------------------------------------------------------------------
// tb_fsm_output_ram_reader
//
// Two readers share one clock and reset:
//    unit 0 : ADDR_WIDTH=16, RAM_LATENCY=1
//    unit 1 : ADDR_WIDTH=4,  RAM_LATENCY=3 (narrow so pointer wrap is cheap)
// Each unit has its own RAM model (a word array plus a RAM_LATENCY-deep
// output pipeline). A reference model tracks the read pointer per unit as a
// plain integer and predicts words, addresses and latency from it.
// ---------------------------------------------------------------------------
module tb_fsm_output_ram_reader;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        startS  [2];
   logic        rewindS [2];
   logic        readyS  [2];
   logic [15:0] wcS     [2];
   logic [31:0] ramS    [2];

   logic [15:0] addrS   [2];
   logic [15:0] availS  [2];
   logic        reS     [2];
   logic        dvS     [2];
   logic        finS    [2];
   logic        empS    [2];
   logic [31:0] doutS   [2];

   logic [3:0]  addr1Narrow;
   logic [3:0]  avail1Narrow;

   logic [31:0] mem  [2][64];
   logic [31:0] pipe [2][4];

   int          rdPtr [2];
   int          latency [2];
   int          mask [2];

   int          nChecks = 0;
   int          nPass   = 0;

   always #5 clk = ~clk;

   fsm_output_ram_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RAM_LATENCY(1)) dut0 (
      .clk                  (clk),
      .reset_n              (reset_n),
      .start                (startS[0]),
      .rewind               (rewindS[0]),
      .write_count          (wcS[0]),
      .ram_data             (ramS[0]),
      .tx_ready             (readyS[0]),
      .address              (addrS[0]),
      .read_enable          (reS[0]),
      .data_to_transmission (doutS[0]),
      .data_valid           (dvS[0]),
      .finished             (finS[0]),
      .empty                (empS[0]),
      .words_available      (availS[0])
   );

   fsm_output_ram_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RAM_LATENCY(3)) dut1 (
      .clk                  (clk),
      .reset_n              (reset_n),
      .start                (startS[1]),
      .rewind               (rewindS[1]),
      .write_count          (wcS[1][3:0]),
      .ram_data             (ramS[1]),
      .tx_ready             (readyS[1]),
      .address              (addr1Narrow),
      .read_enable          (reS[1]),
      .data_to_transmission (doutS[1]),
      .data_valid           (dvS[1]),
      .finished             (finS[1]),
      .empty                (empS[1]),
      .words_available      (avail1Narrow)
   );

   assign addrS[1]  = {12'h000, addr1Narrow};
   assign availS[1] = {12'h000, avail1Narrow};

   // Synchronous RAM: read is registered on the enable edge, then delayed
   // further so data appears RAM_LATENCY cycles after the enable cycle.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (reS[u]) pipe[u][0] <= mem[u][addrS[u][5:0]];
         for (int k = 1; k < 4; k++) pipe[u][k] <= pipe[u][k-1];
      end
   end
   assign ramS[0] = pipe[0][0];
   assign ramS[1] = pipe[1][2];

   function automatic logic [15:0] modelAvail(input int u);
      return 16'((int'(wcS[u]) - rdPtr[u]) & mask[u]);
   endfunction

   function automatic logic [31:0] modelWord(input int u);
      return mem[u][rdPtr[u] & 63];
   endfunction

   task automatic applyReset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      rdPtr[0] = 0;
      rdPtr[1] = 0;
   endtask

   // Issues one start and watches the whole transaction, measuring latency
   // (in cycles after the start edge), handshake length and pulses.
   task automatic readWord(input int u, input int stall, output int lat,
                           output logic [15:0] seenAddr, output logic [31:0] word,
                           output int dvCycles, output int finCount, output int reCount,
                           output int unstable, output int timedOut);
      int finCyc;
      lat = -1; seenAddr = '0; word = '0; dvCycles = 0; finCount = 0;
      reCount = 0; unstable = 0; timedOut = 1; finCyc = -1;
      @(negedge clk);
      startS[u] = 1'b1;
      readyS[u] = 1'b0;
      @(negedge clk);
      startS[u] = 1'b0;
      for (int c = 1; c < 60; c++) begin
         if (c > 1) @(negedge clk);
         if (reS[u]) begin
            reCount++;
            seenAddr = addrS[u];
         end
         if (dvS[u]) begin
            dvCycles++;
            if (lat < 0) begin
               lat  = c;
               word = doutS[u];
            end else if (doutS[u] !== word) begin
               unstable++;
            end
         end
         readyS[u] = dvS[u] && (dvCycles > stall);
         if (finS[u]) begin
            finCount++;
            if (finCyc < 0) finCyc = c;
         end
         if (finCyc >= 0 && c == finCyc + 2) begin
            timedOut = 0;
            break;
         end
      end
      readyS[u] = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         nChecks++; if (addrS[u] !== 16'h0) $display("[TB] FAIL reset_addr u%0d: got %h want 0", u, addrS[u]); else nPass++;
         nChecks++; if (reS[u] !== 1'b0) $display("[TB] FAIL reset_re u%0d: got %b want 0", u, reS[u]); else nPass++;
         nChecks++; if (dvS[u] !== 1'b0) $display("[TB] FAIL reset_dv u%0d: got %b want 0", u, dvS[u]); else nPass++;
         nChecks++; if (finS[u] !== 1'b0) $display("[TB] FAIL reset_fin u%0d: got %b want 0", u, finS[u]); else nPass++;
         nChecks++; if (doutS[u] !== 32'h0) $display("[TB] FAIL reset_dout u%0d: got %h want 0", u, doutS[u]); else nPass++;
         nChecks++; if (empS[u] !== 1'b1) $display("[TB] FAIL reset_empty u%0d: got %b want 1", u, empS[u]); else nPass++;
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic_read();
      int lat, dvc, fc, rc, uns, to;
      logic [15:0] a;
      logic [31:0] w;
      mem[0][0] = 32'hA0A0_0001;
      mem[0][1] = 32'hA0A0_0002;
      mem[0][2] = 32'hA0A0_0003;
      wcS[0] = 16'd3;
      for (int i = 0; i < 3; i++) begin
         readWord(0, 0, lat, a, w, dvc, fc, rc, uns, to);
         nChecks++; if (to != 0) $display("[TB] FAIL basic_timeout[%0d]: got timeout want completion", i); else nPass++;
         nChecks++; if (a !== 16'(i)) $display("[TB] FAIL basic_addr[%0d]: got %h want %h", i, a, 16'(i)); else nPass++;
         nChecks++; if (w !== 32'hA0A0_0001 + 32'(i)) $display("[TB] FAIL basic_word[%0d]: got %h want %h", i, w, 32'hA0A0_0001 + 32'(i)); else nPass++;
         nChecks++; if (lat != 3) $display("[TB] FAIL basic_latency[%0d]: got %0d want 3", i, lat); else nPass++;
         nChecks++; if (fc != 1) $display("[TB] FAIL basic_finished[%0d]: got %0d pulses want 1", i, fc); else nPass++;
         nChecks++; if (rc != 1) $display("[TB] FAIL basic_reads[%0d]: got %0d want 1", i, rc); else nPass++;
         rdPtr[0] = rdPtr[0] + 1;
      end
      nChecks++; if (empS[0] !== 1'b1) $display("[TB] FAIL basic_empty: got %b want 1", empS[0]); else nPass++;
      nChecks++; if (availS[0] !== 16'h0) $display("[TB] FAIL basic_avail: got %h want 0", availS[0]); else nPass++;
   endtask

   task automatic test_empty();
      int reSeen, finSeen, availBad;
      applyReset();
      wcS[0] = 16'h0;
      reSeen = 0; finSeen = 0; availBad = 0;
      startS[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (reS[0] !== 1'b0) reSeen++;
         if (finS[0] !== 1'b0) finSeen++;
         if (availS[0] !== 16'h0) availBad++;
      end
      startS[0] = 1'b0;
      nChecks++; if (reSeen != 0) $display("[TB] FAIL empty_read_enable: got %0d cycles want 0", reSeen); else nPass++;
      nChecks++; if (finSeen != 0) $display("[TB] FAIL empty_finished: got %0d cycles want 0", finSeen); else nPass++;
      nChecks++; if (availBad != 0) $display("[TB] FAIL empty_avail: got %0d nonzero cycles want 0", availBad); else nPass++;
   endtask

   task automatic test_backpressure();
      int lat, dvc, fc, rc, uns, to;
      logic [15:0] a;
      logic [31:0] w, expW;
      wcS[0] = 16'(rdPtr[0] + 1);
      expW = modelWord(0);
      readWord(0, 7, lat, a, w, dvc, fc, rc, uns, to);
      nChecks++; if (to != 0) $display("[TB] FAIL bp_timeout: got timeout want completion"); else nPass++;
      nChecks++; if (dvc != 8) $display("[TB] FAIL bp_valid_cycles: got %0d want 8", dvc); else nPass++;
      nChecks++; if (uns != 0) $display("[TB] FAIL bp_stable: got %0d changes want 0", uns); else nPass++;
      nChecks++; if (w !== expW) $display("[TB] FAIL bp_word: got %h want %h", w, expW); else nPass++;
      nChecks++; if (fc != 1) $display("[TB] FAIL bp_finished: got %0d want 1", fc); else nPass++;
      rdPtr[0] = rdPtr[0] + 1;
      nChecks++; if (availS[0] !== modelAvail(0)) $display("[TB] FAIL bp_ptr_once: got avail %h want %h", availS[0], modelAvail(0)); else nPass++;
   endtask

   task automatic test_random(input int u, input int iters);
      int lat, dvc, fc, rc, uns, to, stall;
      logic [15:0] a;
      logic [31:0] w, expW;
      for (int i = 0; i < iters; i++) begin
         wcS[u] = 16'((int'(wcS[u]) + int'($urandom_range(0, 2))) & mask[u]);
         if (modelAvail(u) == 16'h0) wcS[u] = 16'((int'(wcS[u]) + 1) & mask[u]);
         @(negedge clk);
         nChecks++; if (availS[u] !== modelAvail(u)) $display("[TB] FAIL rand_avail u%0d[%0d]: got %h want %h", u, i, availS[u], modelAvail(u)); else nPass++;
         stall = int'($urandom_range(0, 3));
         expW  = modelWord(u);
         readWord(u, stall, lat, a, w, dvc, fc, rc, uns, to);
         nChecks++; if (to != 0) $display("[TB] FAIL rand_timeout u%0d[%0d]: got timeout want completion", u, i); else nPass++;
         nChecks++; if (a !== 16'(rdPtr[u])) $display("[TB] FAIL rand_addr u%0d[%0d]: got %h want %h", u, i, a, 16'(rdPtr[u])); else nPass++;
         nChecks++; if (w !== expW) $display("[TB] FAIL rand_word u%0d[%0d]: got %h want %h", u, i, w, expW); else nPass++;
         nChecks++; if (lat != latency[u] + 2) $display("[TB] FAIL rand_latency u%0d[%0d]: got %0d want %0d", u, i, lat, latency[u] + 2); else nPass++;
         nChecks++; if (dvc != stall + 1 || uns != 0) $display("[TB] FAIL rand_hold u%0d[%0d]: got %0d cycles/%0d changes want %0d/0", u, i, dvc, uns, stall + 1); else nPass++;
         nChecks++; if (fc != 1) $display("[TB] FAIL rand_finished u%0d[%0d]: got %0d want 1", u, i, fc); else nPass++;
         rdPtr[u] = (rdPtr[u] + 1) & mask[u];
      end
   endtask

   task automatic test_latency();
      int lat, dvc, fc, rc, uns, to;
      logic [15:0] a;
      logic [31:0] w, expW;
      wcS[1] = 16'((rdPtr[1] + 2) & mask[1]);
      for (int i = 0; i < 2; i++) begin
         expW = modelWord(1);
         readWord(1, 0, lat, a, w, dvc, fc, rc, uns, to);
         nChecks++; if (lat != 5) $display("[TB] FAIL lat3_latency[%0d]: got %0d want 5", i, lat); else nPass++;
         nChecks++; if (w !== expW) $display("[TB] FAIL lat3_word[%0d]: got %h want %h", i, w, expW); else nPass++;
         rdPtr[1] = (rdPtr[1] + 1) & mask[1];
      end
   endtask

   task automatic test_wrap_rewind();
      int lat, dvc, fc, rc, uns, to, addrBad, reSeen;
      logic [15:0] a;
      logic [31:0] w;
      wcS[1] = 16'd15;
      addrBad = 0;
      while (rdPtr[1] != 15) begin
         readWord(1, int'($urandom_range(0, 2)), lat, a, w, dvc, fc, rc, uns, to);
         if (a !== 16'(rdPtr[1]) || to != 0 || w !== modelWord(1)) addrBad++;
         rdPtr[1] = rdPtr[1] + 1;
      end
      nChecks++; if (addrBad != 0) $display("[TB] FAIL wrap_fill: got %0d bad reads want 0", addrBad); else nPass++;
      wcS[1] = 16'd1;
      @(negedge clk);
      nChecks++; if (availS[1] !== 16'd2) $display("[TB] FAIL wrap_avail: got %h want 2", availS[1]); else nPass++;
      readWord(1, 0, lat, a, w, dvc, fc, rc, uns, to);
      nChecks++; if (a !== 16'h000F) $display("[TB] FAIL wrap_addr_top: got %h want 000f", a); else nPass++;
      readWord(1, 0, lat, a, w, dvc, fc, rc, uns, to);
      nChecks++; if (a !== 16'h0000 || w !== mem[1][0]) $display("[TB] FAIL wrap_addr_zero: got %h/%h want 0000/%h", a, w, mem[1][0]); else nPass++;
      rdPtr[1] = 1;
      nChecks++; if (empS[1] !== 1'b1) $display("[TB] FAIL wrap_empty: got %b want 1", empS[1]); else nPass++;
      // rewind together with start: pointer clears, no read follows
      wcS[1] = 16'd5;
      @(negedge clk);
      rewindS[1] = 1'b1;
      startS[1]  = 1'b1;
      @(negedge clk);
      rewindS[1] = 1'b0;
      startS[1]  = 1'b0;
      rdPtr[1] = 0;
      reSeen = (reS[1] === 1'b1) ? 1 : 0;
      nChecks++; if (availS[1] !== 16'd5) $display("[TB] FAIL rewind_avail: got %h want 5", availS[1]); else nPass++;
      @(negedge clk);
      if (reS[1] === 1'b1) reSeen++;
      nChecks++; if (reSeen != 0) $display("[TB] FAIL rewind_no_read: got %0d read cycles want 0", reSeen); else nPass++;
   endtask

   task automatic test_reset_mid();
      int lat, dvc, fc, rc, uns, to;
      logic [15:0] a;
      logic [31:0] w;
      // reset while unit 1 sits in WAIT
      wcS[1] = 16'd5;
      @(negedge clk);
      startS[1] = 1'b1;
      @(negedge clk);
      startS[1] = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      nChecks++; if (doutS[0] !== 32'h0 || doutS[1] !== 32'h0) $display("[TB] FAIL rstwait_dout: got %h/%h want 0/0", doutS[0], doutS[1]); else nPass++;
      nChecks++; if (reS[1] !== 1'b0 || dvS[1] !== 1'b0 || finS[1] !== 1'b0 || addrS[1] !== 16'h0) $display("[TB] FAIL rstwait_ctrl: got re=%b dv=%b fin=%b addr=%h want all 0", reS[1], dvS[1], finS[1], addrS[1]); else nPass++;
      @(negedge clk);
      reset_n = 1'b1;
      rdPtr[0] = 0;
      rdPtr[1] = 0;
      readWord(1, 0, lat, a, w, dvc, fc, rc, uns, to);
      nChecks++; if (a !== 16'h0 || lat != 5 || w !== mem[1][0]) $display("[TB] FAIL rstwait_recover: got addr %h lat %0d word %h want 0/5/%h", a, lat, w, mem[1][0]); else nPass++;
      rdPtr[1] = 1;
      // reset while unit 0 sits in PRESENT with a nonzero pointer
      wcS[0] = 16'd3;
      readWord(0, 0, lat, a, w, dvc, fc, rc, uns, to);
      rdPtr[0] = 1;
      @(negedge clk);
      startS[0] = 1'b1;
      readyS[0] = 1'b0;
      @(negedge clk);
      startS[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nChecks++; if (dvS[0] !== 1'b1 || doutS[0] !== mem[0][1]) $display("[TB] FAIL rstpres_setup: got dv=%b word %h want 1/%h", dvS[0], doutS[0], mem[0][1]); else nPass++;
      #2 reset_n = 1'b0;
      #1;
      nChecks++; if (dvS[0] !== 1'b0 || doutS[0] !== 32'h0 || finS[0] !== 1'b0) $display("[TB] FAIL rstpres_outputs: got dv=%b dout=%h fin=%b want 0", dvS[0], doutS[0], finS[0]); else nPass++;
      nChecks++; if (availS[0] !== 16'd3) $display("[TB] FAIL rstpres_ptr: got avail %h want 3", availS[0]); else nPass++;
      @(negedge clk);
      reset_n = 1'b1;
      rdPtr[0] = 0;
      readWord(0, 0, lat, a, w, dvc, fc, rc, uns, to);
      nChecks++; if (a !== 16'h0 || w !== mem[0][0] || fc != 1) $display("[TB] FAIL rstpres_recover: got addr %h word %h fin %0d want 0/%h/1", a, w, fc, mem[0][0]); else nPass++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      mask[0] = 16'hFFFF;
      mask[1] = 16'h000F;
      latency[0] = 1;
      latency[1] = 3;
      for (int u = 0; u < 2; u++) begin
         startS[u] = 1'b0; rewindS[u] = 1'b0; readyS[u] = 1'b0; wcS[u] = 16'h0;
         rdPtr[u] = 0;
         for (int k = 0; k < 4; k++) pipe[u][k] = 32'h0;
         for (int k = 0; k < 64; k++) mem[u][k] = $urandom | 32'h1;
      end
      test_reset();
      test_basic_read();
      test_empty();
      test_backpressure();
      test_random(0, 8);
      test_random(1, 6);
      test_latency();
      test_wrap_rewind();
      test_reset_mid();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
